digit_serial_sub: RTL and testbench

//  Parametrised multi-bit subtractor built on the full-subtractor borrow chain.

---
 rtl/digit_serial_sub.sv | 129 ++++++++++++
 tb/tb_digit_serial_sub.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: diff = a - b - borrowIn over WIDTH bits, DIGIT bits per clock,
// with start/busy/done handshake, borrow-out and signed overflow.
module digit_serial_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow
);
  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             brw_q, brw_d;
  logic             busy_d, done_d, bo_d, ov_d;
  logic [WIDTH-1:0] diff_d;

  logic [DIGIT-1:0] dig_c;
  logic             brw_c, bmsb_c, take_c;
  logic [WIDTH-1:0] res_sh_c;

  // Full-subtractor borrow chain across the low digit of the operand registers
  always_comb begin
    logic br;
    br     = brw_q;
    bmsb_c = 1'b0;
    dig_c  = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      bmsb_c   = br;
      dig_c[i] = a_q[i] ^ b_q[i] ^ br;
      br       = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
    end
    brw_c = br;
  end

  // New digit enters the result from the MSB side
  assign res_sh_c = WIDTH'({dig_c, res_q} >> DIGIT);
  assign take_c   = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    diff_d  = diff;
    bo_d    = borrowOut;
    ov_d    = overflow;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = brw_c;
        res_d = res_sh_c;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = res_sh_c;
          bo_d    = brw_c;
          ov_d    = bmsb_c ^ brw_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance from IDLE or DONE overrides the default transition
    if (take_c) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      brw_d   = borrowIn;
      res_d   = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      brw_q     <= 1'b0;
      res_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrowOut <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      brw_q     <= brw_d;
      res_q     <= res_d;
      busy      <= busy_d;
      done      <= done_d;
      diff      <= diff_d;
      borrowOut <= bo_d;
      overflow  <= ov_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_sub.sv
// Self-checking bench for digit_serial_sub: W8/D1, W1/D1 and W16/D4 instances,
// expected results queued at issue and compared when done pulses.
module tb_digit_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] diff;
    logic        bo;
    logic        ov;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bo;
    logic       ov;
  } vec8_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t q16[$];

  logic        start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        busy8, done8, bo8, ov8;
  logic        start1 = 1'b0, bin1 = 1'b0, a1 = 1'b0, b1 = 1'b0, diff1;
  logic        busy1, done1, bo1, ov1;
  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, diff16;
  logic        busy16, done16, bo16, ov16;

  digit_serial_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrowIn(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrowOut(bo8), .overflow(ov8));

  digit_serial_sub #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrowIn(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrowOut(bo1), .overflow(ov1));

  digit_serial_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .borrowIn(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrowOut(bo16), .overflow(ov16));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard monitors: one per instance, compare on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL u8 spurious done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("u8 diff", diff8, e.diff);
        chk("u8 borrowOut", bo8, e.bo);
        chk("u8 overflow", ov8, e.ov);
        chk("u8 latency", cyc, e.cyc);
        chk("u8 busy with done", busy8, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL u1 spurious done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("u1 diff", diff1, e.diff);
        chk("u1 borrowOut", bo1, e.bo);
        chk("u1 overflow", ov1, e.ov);
        chk("u1 latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done16) begin
      if (q16.size() == 0) begin
        total++;
        $display("FAIL u16 spurious done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        chk("u16 diff", diff16, e.diff);
        chk("u16 borrowOut", bo16, e.bo);
        chk("u16 overflow", ov16, e.ov);
        chk("u16 latency", cyc, e.cyc);
      end
    end
  end

  task automatic drain(input string nm, input int which);
    int n = 0;
    int sz;
    sz = (which == 8) ? q8.size() : (which == 1) ? q1.size() : q16.size();
    while (sz != 0 && n < 40) begin
      @(negedge clk);
      n++;
      sz = (which == 8) ? q8.size() : (which == 1) ? q1.size() : q16.size();
    end
    if (sz != 0) begin
      total++;
      $display("FAIL %s timeout: got %0d pending results expected 0", nm, sz);
      if (which == 8) q8.delete(); else if (which == 1) q1.delete(); else q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] d, input logic bo, input logic ov);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    e.diff = 16'(d); e.bo = bo; e.ov = ov; e.cyc = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    drain("u8", 8);
  endtask

  task automatic go1(input logic a, input logic b, input logic bin);
    exp_t e;
    logic [1:0] r;
    r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    e.diff = 16'(r[0]); e.bo = r[1]; e.ov = (a ^ b) & (a ^ r[0]); e.cyc = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    drain("u1", 1);
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - 17'(bin);
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
    e.diff = r[15:0]; e.bo = r[16]; e.ov = (a[15] ^ b[15]) & (a[15] ^ r[15]); e.cyc = cyc + 5;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    drain("u16", 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected $finish before 1ms");
    $fatal(1);
  end

  initial begin
    vec8_t tbl[8];
    exp_t  e;
    int    n;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[7] = '{8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst u8 busy", busy8, 0);   chk("rst u8 done", done8, 0);
    chk("rst u8 diff", diff8, 0);   chk("rst u8 bo", bo8, 0);   chk("rst u8 ov", ov8, 0);
    chk("rst u1 busy", busy1, 0);   chk("rst u1 done", done1, 0);
    chk("rst u16 busy", busy16, 0); chk("rst u16 diff", diff16, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      go8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff, tbl[i].bo, tbl[i].ov);

    for (int i = 0; i < 8; i++)
      go1(i[2], i[1], i[0]);

    for (int i = 0; i < 1000; i++)
      go16(16'($urandom), 16'($urandom), 1'($urandom));
    go16(16'h0000, 16'hFFFF, 1'b1);
    go16(16'h8000, 16'h0001, 1'b0);

    // start pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
    e.diff = 16'h001B; e.bo = 1'b0; e.ov = 1'b0; e.cyc = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(negedge clk);
    chk("u8 busy mid-RUN", busy8, 1);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain("u8 mid-run start", 8);
    repeat (12) @(negedge clk);

    // start held through DONE: second op accepted back-to-back
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h41; bin8 = 1'b0; start8 = 1'b1;
    e.diff = 16'h00FF; e.bo = 1'b1; e.ov = 1'b0; e.cyc = cyc + 9;
    q8.push_back(e);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("u8 first done seen", done8, 1);
    a8 = 8'h90; b8 = 8'h20; bin8 = 1'b1;
    e.diff = 16'h006F; e.bo = 1'b0; e.ov = 1'b1; e.cyc = cyc + 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    drain("u8 back-to-back", 8);

    // Reset during RUN: outputs clear at once, no done for the aborted op
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("u8 busy before reset", busy8, 1);
    #1 rst = 1'b1;
    #1;
    chk("u8 busy after reset", busy8, 0);
    chk("u8 diff after reset", diff8, 0);
    chk("u8 ov after reset", ov8, 0);
    chk("u8 bo after reset", bo8, 0);
    chk("u8 done after reset", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    go8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    chk("u8 queue empty", q8.size(), 0);
    chk("u1 queue empty", q1.size(), 0);
    chk("u16 queue empty", q16.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
